// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage and the memory.
// Word-wide request/acknowledge with a one-cycle completion strobe.
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: variable-latency data-memory access with
// misaligned-address trapping and bus-timeout abort.
module mem_access_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        regwrite_m,
  input  logic        memtoreg_m,
  input  logic        memwrite_m,
  input  logic        memread_m,
  input  logic [31:0] execout_m,
  input  logic [31:0] writedata_m,
  input  logic [4:0]  writereg_m,
  output logic        mem_stall,
  mem_access_stage_if.master dmem,
  output logic        regwrite_w,
  output logic        memtoreg_w,
  output logic [31:0] readdata_w,
  output logic [31:0] execout_w,
  output logic [4:0]  writereg_w,
  output logic        misalign_err,
  output logic        bus_timeout
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic mem_op;
  logic aligned;
  logic issue;
  logic busy;
  logic timeout_hit;

  assign mem_op  = memread_m | memwrite_m;
  assign aligned = (execout_m[1:0] == 2'b00);
  assign issue   = mem_op & aligned;
  assign busy    = (state == BUSY);

  // The stall entering BUSY counts as the first wait cycle.
  assign timeout_hit = busy && (TIMEOUT != 0) &&
                       (cnt == CW'(TIMEOUT)) && !dmem.dmem_ack;

  assign dmem.dmem_req = !reset &&
                         ((!busy && issue) || (busy && !timeout_hit));
  assign mem_stall     = !reset &&
                         ((!busy && issue && !dmem.dmem_ack) ||
                          (busy && !dmem.dmem_ack && !timeout_hit));

  assign dmem.dmem_we    = memwrite_m;
  assign dmem.dmem_addr  = execout_m;
  assign dmem.dmem_wdata = writedata_m;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      regwrite_w   <= 1'b0;
      memtoreg_w   <= 1'b0;
      readdata_w   <= '0;
      execout_w    <= '0;
      writereg_w   <= '0;
      misalign_err <= 1'b0;
      bus_timeout  <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      bus_timeout  <= 1'b0;

      if (mem_stall) begin
        regwrite_w <= 1'b0;
        memtoreg_w <= 1'b0;
      end else begin
        execout_w  <= execout_m;
        writereg_w <= writereg_m;
        regwrite_w <= regwrite_m;
        memtoreg_w <= memtoreg_m;
        unique case (1'b1)
          mem_op && !aligned: begin
            regwrite_w   <= 1'b0;
            memtoreg_w   <= 1'b0;
            misalign_err <= 1'b1;
          end
          timeout_hit: begin
            regwrite_w  <= 1'b0;
            memtoreg_w  <= 1'b0;
            bus_timeout <= 1'b1;
          end
          issue && dmem.dmem_ack && !memwrite_m: begin
            readdata_w <= dmem.dmem_rdata;
          end
          default: ;
        endcase
      end

      unique case (state)
        IDLE: begin
          if (issue && !dmem.dmem_ack) begin
            state <= BUSY;
            cnt   <= CW'(1);
          end
        end
        BUSY: begin
          if (dmem.dmem_ack || timeout_hit) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a short bus timeout.
// Inputs change on negedge; outputs sampled before/after posedge.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        regwrite_m;
  logic        memtoreg_m;
  logic        memwrite_m;
  logic        memread_m;
  logic [31:0] execout_m;
  logic [31:0] writedata_m;
  logic [4:0]  writereg_m;
  logic        mem_stall;
  logic        regwrite_w;
  logic        memtoreg_w;
  logic [31:0] readdata_w;
  logic [31:0] execout_w;
  logic [4:0]  writereg_w;
  logic        misalign_err;
  logic        bus_timeout;

  int checks = 0;
  int errors = 0;

  mem_access_stage_if bus ();

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .regwrite_m   (regwrite_m),
    .memtoreg_m   (memtoreg_m),
    .memwrite_m   (memwrite_m),
    .memread_m    (memread_m),
    .execout_m    (execout_m),
    .writedata_m  (writedata_m),
    .writereg_m   (writereg_m),
    .mem_stall    (mem_stall),
    .dmem         (bus.master),
    .regwrite_w   (regwrite_w),
    .memtoreg_w   (memtoreg_w),
    .readdata_w   (readdata_w),
    .execout_w    (execout_w),
    .writereg_w   (writereg_w),
    .misalign_err (misalign_err),
    .bus_timeout  (bus_timeout)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic rw, input logic mt,
                       input logic mw, input logic mr,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] wr);
    regwrite_m  = rw;
    memtoreg_m  = mt;
    memwrite_m  = mw;
    memread_m   = mr;
    execout_m   = a;
    writedata_m = wd;
    writereg_m  = wr;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = '0;
    drive(1, 1, 0, 1, 32'h100, 0, 5'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (bus.dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_comb req=%b stall=%b exp 0 0",
               bus.dmem_req, mem_stall);
    end
    checks++;
    if ({regwrite_w, memtoreg_w, readdata_w, execout_w,
         writereg_w, misalign_err, bus_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_regs rw=%b mt=%b rd=%h ex=%h wr=%0d me=%b bt=%b exp all 0",
               regwrite_w, memtoreg_w, readdata_w, execout_w,
               writereg_w, misalign_err, bus_timeout);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  task automatic test_alu;
    @(negedge clk);
    drive(1, 0, 0, 0, 32'h1234, 0, 5'd7);
    #1;
    checks++;
    if (mem_stall !== 1'b0 || bus.dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL alu_comb stall=%b req=%b exp 0 0",
               mem_stall, bus.dmem_req);
    end
    @(posedge clk);
    #1;
    checks++;
    if (regwrite_w !== 1'b1 || execout_w !== 32'h1234 ||
        writereg_w !== 5'd7 || memtoreg_w !== 1'b0) begin
      errors++;
      $display("FAIL alu_retire rw=%b ex=%h wr=%0d mt=%b exp 1 1234 7 0",
               regwrite_w, execout_w, writereg_w, memtoreg_w);
    end
  endtask

  task automatic test_load_wait;
    int stalls = 0;
    int reqs = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(1, 1, 0, 1, 32'h100, 0, 5'd5);
      bus.dmem_ack   = (c == 3);
      bus.dmem_rdata = (c == 3) ? 32'hDEADBEEF : 32'h0;
      #1;
      if (mem_stall === 1'b1) stalls++;
      if (bus.dmem_req === 1'b1) reqs++;
      checks++;
      if (bus.dmem_we !== 1'b0 || bus.dmem_addr !== 32'h100) begin
        errors++;
        $display("FAIL load_bus c=%0d we=%b addr=%h exp 0 100",
                 c, bus.dmem_we, bus.dmem_addr);
      end
      @(posedge clk);
      #1;
      if (c < 3) begin
        checks++;
        if (regwrite_w !== 1'b0 || memtoreg_w !== 1'b0) begin
          errors++;
          $display("FAIL load_bubble c=%0d rw=%b mt=%b exp 0 0",
                   c, regwrite_w, memtoreg_w);
        end
      end
    end
    checks++;
    if (stalls != 3 || reqs != 4) begin
      errors++;
      $display("FAIL load_counts stalls=%0d reqs=%0d exp 3 4",
               stalls, reqs);
    end
    checks++;
    if (readdata_w !== 32'hDEADBEEF || regwrite_w !== 1'b1 ||
        memtoreg_w !== 1'b1 || writereg_w !== 5'd5) begin
      errors++;
      $display("FAIL load_retire rd=%h rw=%b mt=%b wr=%0d exp deadbeef 1 1 5",
               readdata_w, regwrite_w, memtoreg_w, writereg_w);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    drive(0, 0, 1, 0, 32'h200, 32'hA5A5A5A5, 5'd0);
    bus.dmem_ack = 1'b1;
    #1;
    checks++;
    if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b1 ||
        mem_stall !== 1'b0 || bus.dmem_wdata !== 32'hA5A5A5A5 ||
        bus.dmem_addr !== 32'h200) begin
      errors++;
      $display("FAIL store_comb req=%b we=%b stall=%b wd=%h a=%h exp 1 1 0 a5a5a5a5 200",
               bus.dmem_req, bus.dmem_we, mem_stall,
               bus.dmem_wdata, bus.dmem_addr);
    end
    @(posedge clk);
    #1;
    checks++;
    if (regwrite_w !== 1'b0 || execout_w !== 32'h200 ||
        readdata_w !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL store_retire rw=%b ex=%h rd=%h exp 0 200 deadbeef",
               regwrite_w, execout_w, readdata_w);
    end
    @(negedge clk);
    drive(1, 1, 0, 1, 32'h204, 0, 5'd9);
    bus.dmem_rdata = 32'h11223344;
    #1;
    checks++;
    if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b0 ||
        mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL b2b_comb req=%b we=%b stall=%b exp 1 0 0",
               bus.dmem_req, bus.dmem_we, mem_stall);
    end
    @(posedge clk);
    #1;
    checks++;
    if (readdata_w !== 32'h11223344 || regwrite_w !== 1'b1 ||
        writereg_w !== 5'd9) begin
      errors++;
      $display("FAIL b2b_retire rd=%h rw=%b wr=%0d exp 11223344 1 9",
               readdata_w, regwrite_w, writereg_w);
    end
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_misalign;
    @(negedge clk);
    drive(1, 1, 0, 1, 32'h103, 0, 5'd3);
    #1;
    checks++;
    if (bus.dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL misalign_comb req=%b stall=%b exp 0 0",
               bus.dmem_req, mem_stall);
    end
    @(posedge clk);
    #1;
    checks++;
    if (misalign_err !== 1'b1 || regwrite_w !== 1'b0 ||
        memtoreg_w !== 1'b0 || execout_w !== 32'h103 ||
        writereg_w !== 5'd3) begin
      errors++;
      $display("FAIL misalign_retire me=%b rw=%b mt=%b ex=%h wr=%0d exp 1 0 0 103 3",
               misalign_err, regwrite_w, memtoreg_w, execout_w, writereg_w);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 32'h8, 0, 5'd0);
    @(posedge clk);
    #1;
    checks++;
    if (misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL misalign_pulse me=%b exp 0", misalign_err);
    end
  endtask

  task automatic test_timeout;
    int stalls = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(1, 1, 0, 1, 32'h300, 0, 5'd4);
      #1;
      if (mem_stall === 1'b1) stalls++;
      if (c == 4) begin
        checks++;
        if (mem_stall !== 1'b0 || bus.dmem_req !== 1'b0) begin
          errors++;
          $display("FAIL timeout_comb stall=%b req=%b exp 0 0",
                   mem_stall, bus.dmem_req);
        end
      end
      @(posedge clk);
    end
    #1;
    checks++;
    if (stalls != 4) begin
      errors++;
      $display("FAIL timeout_stalls got %0d exp 4", stalls);
    end
    checks++;
    if (bus_timeout !== 1'b1 || regwrite_w !== 1'b0 ||
        memtoreg_w !== 1'b0 || execout_w !== 32'h300) begin
      errors++;
      $display("FAIL timeout_retire bt=%b rw=%b mt=%b ex=%h exp 1 0 0 300",
               bus_timeout, regwrite_w, memtoreg_w, execout_w);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 32'h0, 0, 5'd0);
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'h00000BAD;
    #1;
    checks++;
    if (bus.dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL stray_comb req=%b stall=%b exp 0 0",
               bus.dmem_req, mem_stall);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus_timeout !== 1'b0 || readdata_w !== 32'h11223344) begin
      errors++;
      $display("FAIL stray_ack bt=%b rd=%h exp 0 11223344",
               bus_timeout, readdata_w);
    end
    @(negedge clk);
    bus.dmem_ack = 1'b0;
  endtask

  task automatic test_reset_busy;
    @(negedge clk);
    drive(1, 1, 0, 1, 32'h400, 0, 5'd6);
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (mem_stall !== 1'b1 || bus.dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL busy_comb stall=%b req=%b exp 1 1",
               mem_stall, bus.dmem_req);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL rstbusy_comb req=%b stall=%b exp 0 0",
               bus.dmem_req, mem_stall);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({regwrite_w, memtoreg_w, readdata_w, execout_w,
         writereg_w, misalign_err, bus_timeout} !== '0) begin
      errors++;
      $display("FAIL rstbusy_regs rw=%b rd=%h ex=%h wr=%0d exp all 0",
               regwrite_w, readdata_w, execout_w, writereg_w);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 0, 5'd0);
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'hCAFEF00D;
    #1;
    checks++;
    if (bus.dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL late_ack_comb req=%b stall=%b exp 0 0",
               bus.dmem_req, mem_stall);
    end
    @(posedge clk);
    #1;
    checks++;
    if (readdata_w !== 32'h0 || regwrite_w !== 1'b0) begin
      errors++;
      $display("FAIL late_ack rd=%h rw=%b exp 0 0", readdata_w, regwrite_w);
    end
    @(negedge clk);
    drive(1, 1, 0, 1, 32'h500, 0, 5'd2);
    bus.dmem_rdata = 32'h55;
    #1;
    checks++;
    if (mem_stall !== 1'b0 || bus.dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL post_rst_idle stall=%b req=%b exp 0 1",
               mem_stall, bus.dmem_req);
    end
    @(posedge clk);
    #1;
    checks++;
    if (readdata_w !== 32'h55 || regwrite_w !== 1'b1) begin
      errors++;
      $display("FAIL post_rst_load rd=%h rw=%b exp 55 1",
               readdata_w, regwrite_w);
    end
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_back_to_back();
    test_misalign();
    test_timeout();
    test_reset_busy();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
